// File: rtl/dmem_arbiter_if.sv
// ============================================================================
//  Module   : dmem_arbiter_if
//  Purpose  : Requester and memory-command bundle for the dual-port data
//             memory arbiter (port 0 = core, port 1 = loader/debug).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dmem_arbiter_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                  i_req0;
   logic                  i_wen0;
   logic [ADDR_WIDTH-1:0] i_addr0;
   logic [DATA_WIDTH-1:0] i_wdata0;
   logic                  i_req1;
   logic                  i_wen1;
   logic [ADDR_WIDTH-1:0] i_addr1;
   logic [DATA_WIDTH-1:0] i_wdata1;
   logic                  i_lock1;
   logic                  o_gnt0;
   logic                  o_gnt1;
   logic                  o_stall0;
   logic                  o_rvalid0;
   logic                  o_rvalid1;
   logic [DATA_WIDTH-1:0] o_rdata0;
   logic [DATA_WIDTH-1:0] o_rdata1;
   logic [ADDR_WIDTH-1:0] o_mem_addr;
   logic [DATA_WIDTH-1:0] o_mem_wdata;
   logic                  o_mem_ren;
   logic                  o_mem_wen;
   logic [DATA_WIDTH-1:0] i_mem_rdata;

   // Arbiter side
   modport slave (
      input  i_req0, i_wen0, i_addr0, i_wdata0,
      input  i_req1, i_wen1, i_addr1, i_wdata1, i_lock1,
      input  i_mem_rdata,
      output o_gnt0, o_gnt1, o_stall0,
      output o_rvalid0, o_rvalid1, o_rdata0, o_rdata1,
      output o_mem_addr, o_mem_wdata, o_mem_ren, o_mem_wen
   );

   // Requesters plus memory side
   modport master (
      output i_req0, i_wen0, i_addr0, i_wdata0,
      output i_req1, i_wen1, i_addr1, i_wdata1, i_lock1,
      output i_mem_rdata,
      input  o_gnt0, o_gnt1, o_stall0,
      input  o_rvalid0, o_rvalid1, o_rdata0, o_rdata1,
      input  o_mem_addr, o_mem_wdata, o_mem_ren, o_mem_wen
   );
endinterface

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
//  Module   : dmem_arbiter
//  Purpose  : Two-requester round-robin arbiter onto a single-port synchronous
//             data memory, with a bounded exclusive lock for port 1.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int MAX_LOCK   = 16
) (
   input  wire logic      i_clk,
   input  wire logic      i_rstn,
   dmem_arbiter_if.slave  bus
);

   localparam int                 c_CNT_W    = (MAX_LOCK > 2) ? $clog2(MAX_LOCK) : 1;
   localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(MAX_LOCK - 1);
   localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   state_t             r_state;
   logic [c_CNT_W-1:0] r_lock_cnt;
   logic               r_last_gnt;   // 1 = port 1 was granted last
   logic               r_rvalid0;
   logic               r_rvalid1;

   logic               w_lock_hold;
   logic               w_pick1;
   logic               w_gnt0;
   logic               w_gnt1;
   logic [c_CNT_W-1:0] w_cnt_nxt;

   // An active lock overrides round-robin; a dropped lock falls back to it
   assign w_lock_hold = (r_state == LOCKED) && bus.i_req1 && bus.i_lock1;

   always_comb begin
      w_pick1 = 1'b0;
      if (w_lock_hold) begin
         w_pick1 = 1'b1;
      end else if (bus.i_req0 && bus.i_req1) begin
         w_pick1 = ~r_last_gnt;
      end else begin
         w_pick1 = bus.i_req1;
      end
   end

   assign w_gnt1    = bus.i_req1 && w_pick1;
   assign w_gnt0    = bus.i_req0 && !w_pick1;
   assign w_cnt_nxt = r_lock_cnt + c_CNT_ONE;

   assign bus.o_gnt0   = w_gnt0;
   assign bus.o_gnt1   = w_gnt1;
   assign bus.o_stall0 = bus.i_req0 && !w_gnt0;

   always_comb begin
      bus.o_mem_addr  = {ADDR_WIDTH{1'b0}};
      bus.o_mem_wdata = {DATA_WIDTH{1'b0}};
      bus.o_mem_ren   = 1'b0;
      bus.o_mem_wen   = 1'b0;
      if (w_gnt0) begin
         bus.o_mem_addr  = bus.i_addr0;
         bus.o_mem_wdata = bus.i_wdata0;
         bus.o_mem_ren   = !bus.i_wen0;
         bus.o_mem_wen   = bus.i_wen0;
      end else if (w_gnt1) begin
         bus.o_mem_addr  = bus.i_addr1;
         bus.o_mem_wdata = bus.i_wdata1;
         bus.o_mem_ren   = !bus.i_wen1;
         bus.o_mem_wen   = bus.i_wen1;
      end
   end

   // Memory returns data one cycle after the read command, aligned with rvalid
   assign bus.o_rvalid0 = r_rvalid0;
   assign bus.o_rvalid1 = r_rvalid1;
   assign bus.o_rdata0  = r_rvalid0 ? bus.i_mem_rdata : {DATA_WIDTH{1'b0}};
   assign bus.o_rdata1  = r_rvalid1 ? bus.i_mem_rdata : {DATA_WIDTH{1'b0}};

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_state    <= IDLE;
         r_lock_cnt <= '0;
         r_last_gnt <= 1'b1;
         r_rvalid0  <= 1'b0;
         r_rvalid1  <= 1'b0;
      end else begin
         r_rvalid0 <= w_gnt0 && !bus.i_wen0;
         r_rvalid1 <= w_gnt1 && !bus.i_wen1;

         if (w_gnt0) begin
            r_last_gnt <= 1'b0;
         end else if (w_gnt1) begin
            r_last_gnt <= 1'b1;
         end

         case (r_state)
            IDLE: begin
               if (w_gnt1 && bus.i_lock1) begin
                  r_state    <= LOCKED;
                  r_lock_cnt <= '0;
               end
            end
            LOCKED: begin
               // Expiry leaves last_gnt = 1, so a waiting port 0 wins next cycle
               if (!w_lock_hold || (w_cnt_nxt == c_CNT_LAST)) begin
                  r_state    <= IDLE;
                  r_lock_cnt <= '0;
               end else begin
                  r_lock_cnt <= w_cnt_nxt;
               end
            end
            default: begin
               r_state    <= IDLE;
               r_lock_cnt <= '0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
//  Module   : tb_dmem_arbiter
//  Purpose  : Directed scoreboard bench for dmem_arbiter with a simple
//             synchronous memory model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int ML = 16;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   dmem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   dmem_arbiter #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .MAX_LOCK   (ML)
   ) dut (
      .i_clk  (clk),
      .i_rstn (rstn),
      .bus    (bus)
   );

   // Memory: unwritten locations read back as the inverted address
   logic [DW-1:0] mem [logic [AW-1:0]];
   always @(posedge clk) begin
      if (bus.o_mem_wen) mem[bus.o_mem_addr] = bus.o_mem_wdata;
      if (bus.o_mem_ren)
         bus.i_mem_rdata <= mem.exists(bus.o_mem_addr) ? mem[bus.o_mem_addr] : ~bus.o_mem_addr;
   end

   typedef struct packed {
      logic          g0;
      logic          g1;
      logic          stall0;
      logic          ren;
      logic          wen;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } gexp_t;

   typedef struct {
      logic          port;
      logic [DW-1:0] data;
      int            due;
   } rexp_t;

   gexp_t gq[$];
   rexp_t rq[$];
   int    cyc_n   = 0;
   int    n_checks = 0;
   int    n_fail   = 0;

   always @(posedge clk) cyc_n <= cyc_n + 1;

   task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @cycle %0d: got %h, expected %h", name, cyc_n, act, exp);
      end
   endtask

   task automatic step(input logic r0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic r1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                       input logic l1, input logic eg0, input logic eg1, input logic [DW-1:0] erd,
                       input logic rst_mid);
      gexp_t e;
      bus.i_req0   = r0;  bus.i_wen0 = w0;  bus.i_addr0 = a0;  bus.i_wdata0 = d0;
      bus.i_req1   = r1;  bus.i_wen1 = w1;  bus.i_addr1 = a1;  bus.i_wdata1 = d1;
      bus.i_lock1  = l1;
      e.g0     = eg0;
      e.g1     = eg1;
      e.stall0 = r0 && !eg0;
      e.ren    = (eg0 && !w0) || (eg1 && !w1);
      e.wen    = (eg0 && w0) || (eg1 && w1);
      e.addr   = eg0 ? a0 : (eg1 ? a1 : '0);
      e.wdata  = eg0 ? d0 : (eg1 ? d1 : '0);
      gq.push_back(e);
      if (!rst_mid && e.ren) rq.push_back('{port: eg1, data: erd, due: cyc_n + 1});
      if (rst_mid) begin
         #2;
         rstn = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      step(0, 0, '0, '0, 0, 0, '0, '0, 0, 0, 0, '0, 0);
   endtask

   // Monitor: grant/command every driven cycle, read responses every cycle
   always @(negedge clk) begin : p_mon
      gexp_t         e;
      logic          ev0, ev1;
      logic [DW-1:0] ed0, ed1;
      if (gq.size() > 0) begin
         e = gq.pop_front();
         chk("grant", 96'({bus.o_gnt0, bus.o_gnt1, bus.o_stall0}), 96'({e.g0, e.g1, e.stall0}));
         chk("mem_cmd", 96'({bus.o_mem_ren, bus.o_mem_wen, bus.o_mem_addr, bus.o_mem_wdata}),
             96'({e.ren, e.wen, e.addr, e.wdata}));
      end
      ev0 = 1'b0; ev1 = 1'b0; ed0 = '0; ed1 = '0;
      while (rq.size() > 0 && rq[0].due <= cyc_n) begin
         if (rq[0].port) begin ev1 = 1'b1; ed1 = rq[0].data; end
         else            begin ev0 = 1'b1; ed0 = rq[0].data; end
         void'(rq.pop_front());
      end
      chk("rsp0", 96'({bus.o_rvalid0, bus.o_rdata0}), 96'({ev0, ed0}));
      chk("rsp1", 96'({bus.o_rvalid1, bus.o_rdata1}), 96'({ev1, ed1}));
   end

   initial begin
      bus.i_req0 = 0; bus.i_wen0 = 0; bus.i_addr0 = '0; bus.i_wdata0 = '0;
      bus.i_req1 = 0; bus.i_wen1 = 0; bus.i_addr1 = '0; bus.i_wdata1 = '0;
      bus.i_lock1 = 0;
      mem[32'h10] = 32'hDEAD_BEEF;
      repeat (3) @(posedge clk);
      #1;
      rstn = 1'b1;

      // Contention straight after reset: 0,1,0,1
      step(1, 0, 'h40, '0, 1, 0, 'h80, '0, 0, 1, 0, 32'hFFFF_FFBF, 0);
      step(1, 0, 'h44, '0, 1, 0, 'h80, '0, 0, 0, 1, 32'hFFFF_FF7F, 0);
      step(1, 0, 'h44, '0, 1, 0, 'h84, '0, 0, 1, 0, 32'hFFFF_FFBB, 0);
      step(1, 0, 'h48, '0, 1, 0, 'h84, '0, 0, 0, 1, 32'hFFFF_FF7B, 0);

      // Single requesters, read / write / read-back
      step(1, 0, 'h10, '0, 0, 0, '0, '0, 0, 1, 0, 32'hDEAD_BEEF, 0);
      step(0, 0, '0, '0, 1, 0, 'h10, '0, 0, 0, 1, 32'hDEAD_BEEF, 0);
      step(1, 1, 'h10, 32'h1234_5678, 0, 0, '0, '0, 0, 1, 0, '0, 0);
      step(1, 0, 'h10, '0, 0, 0, '0, '0, 0, 1, 0, 32'h1234_5678, 0);

      // Locked burst of four writes, port 0 served once the lock drops
      step(1, 0, 'h20, '0, 1, 1, 'h100, 32'hA0, 1, 0, 1, '0, 0);
      step(1, 0, 'h20, '0, 1, 1, 'h104, 32'hA1, 1, 0, 1, '0, 0);
      step(1, 0, 'h20, '0, 1, 1, 'h108, 32'hA2, 1, 0, 1, '0, 0);
      step(1, 0, 'h20, '0, 1, 1, 'h10C, 32'hA3, 1, 0, 1, '0, 0);
      step(1, 0, 'h20, '0, 0, 0, '0, '0, 0, 1, 0, 32'hFFFF_FFDF, 0);
      step(0, 0, '0, '0, 1, 0, 'h104, '0, 0, 0, 1, 32'hA1, 0);

      // Lock held 40 cycles: port 0 every 17th cycle (16 port-1 grants between)
      for (int i = 0; i < 40; i++) begin
         step(1, 0, 'h30, '0, 1, 1, 'h200, 32'h55, 1,
              (i % 17) == 0, (i % 17) != 0, 32'hFFFF_FFCF, 0);
      end

      // Reset lands in the cycle of a port-0 read grant
      step(1, 0, 'h10, '0, 0, 0, '0, '0, 0, 1, 0, '0, 1);
      idle();
      rstn = 1'b1;
      step(1, 0, 'h50, '0, 1, 0, 'h60, '0, 0, 1, 0, 32'hFFFF_FFAF, 0);
      idle();
      idle();
      @(negedge clk);
      #1;
      chk("queues_drained", 96'(gq.size() + rq.size()), 96'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
